// File: rtl/lsu_vec_pkg.sv
// lsu_vec_pkg: shared types for the vector load/store unit.
//   decode_s            - EXE-stage memory op decode
//   load_info_s         - load bookkeeping carried with a remote request
//   remote_req_s        - request word presented to network TX
//   lsu_vec_state_e     - FSM state encoding (IDLE/SEND/BURST)
//   lsu_vec_lane_mask_t - one bit per SIMD lane, sized for the widest build
package lsu_vec_pkg;

  localparam int          lsu_vec_max_lanes_gp   = 8;
  localparam logic [31:0] bsg_dram_npa_prefix_gp = 32'h8000_0000;

  typedef logic [lsu_vec_max_lanes_gp-1:0] lsu_vec_lane_mask_t;

  typedef logic [1:0] lsu_vec_state_e;
  localparam lsu_vec_state_e LSU_IDLE  = 2'd0;
  localparam lsu_vec_state_e LSU_SEND  = 2'd1;
  localparam lsu_vec_state_e LSU_BURST = 2'd2;

  typedef struct packed {
    logic       load;
    logic       store;
    logic       simd;
    logic       is_byte;
    logic       is_hex;
    logic       amo;
    logic [3:0] amo_type;
    logic       is_unsigned;
    logic       write_frd;
    logic       lr;
  } decode_s;

  typedef struct packed {
    logic       float_wb;
    logic       icache_fetch;
    logic       is_unsigned_op;
    logic       is_byte_op;
    logic       is_hex_op;
    logic [1:0] part_sel;
  } load_info_s;

  typedef struct packed {
    logic       write_not_read;
    logic       is_amo;
    logic [3:0] amo_type;
    logic [3:0] mask;
    logic [31:0] payload;
    logic [4:0] reg_id;
    logic [31:0] addr;
    load_info_s load_info;
  } remote_req_s;

endpackage

// File: rtl/lsu_vec_if.sv
// lsu_vec_if: remote request channel between the LSU and network TX.
//   remote_req       - request fields (held stable while valid)
//   remote_req_v     - request valid
//   remote_req_ready - TX accepts the request this cycle
// master = LSU side, slave = TX side.
interface lsu_vec_if;
  import lsu_vec_pkg::*;

  remote_req_s remote_req;
  logic        remote_req_v;
  logic        remote_req_ready;

  modport master (output remote_req, output remote_req_v, input remote_req_ready);
  modport slave  (input remote_req, input remote_req_v, output remote_req_ready);
endinterface

// File: rtl/lsu_vec_store_fmt.sv
// lsu_vec_store_fmt: formats one store word and its byte mask.
//   i_data  - raw store word
//   i_byte  - byte op: byte replicated x4, one-hot mask on i_sel
//   i_hex   - halfword op: halfword replicated x2, mask picks the half by i_sel[1]
//   i_sel   - address bits [1:0]
//   o_data  - formatted store word
//   o_mask  - byte enables
module lsu_vec_store_fmt
  import lsu_vec_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic        i_byte,
  input  logic        i_hex,
  input  logic [1:0]  i_sel,
  output logic [31:0] o_data,
  output logic [3:0]  o_mask
);
  always_comb begin
    o_data = i_data;
    o_mask = 4'hF;
    if (i_byte) begin
      o_data = {4{i_data[7:0]}};
      o_mask = 4'b0001 << i_sel;
    end else if (i_hex) begin
      o_data = {2{i_data[15:0]}};
      o_mask = {{2{i_sel[1]}}, {2{~i_sel[1]}}};
    end
  end
endmodule

// File: rtl/lsu_vec.sv
// lsu_vec: load/store unit for a lanes_p-wide SIMD vanilla core.
//   clk_i, reset_n_i        - clock, async active-low reset
//   exe_v_i / exe_ready_o   - op handshake from EXE (ready only in IDLE)
//   exe_decode_i, exe_rs1_i, exe_rs2_i, exe_rd_i, mem_offset_i - op operands
//   pc_plus4_i, icache_miss_i - icache-miss fetch request
//   dmem_*_o, byte_sel_o    - same-cycle local DMEM access
//   remote                  - registered remote request (lsu_vec_if.master)
//   misalign_o              - local SIMD op not row-aligned (op dropped)
// Build option: LSU_VEC_REMOTE_SIMD_EN enables splitting remote SIMD ops
// into lanes_p word beats; without it only lane 0 is sent.
module lsu_vec
  import lsu_vec_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int dmem_size_p  = 1024,
  parameter int lanes_p      = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             exe_v_i,
  output logic                             exe_ready_o,
  input  decode_s                          exe_decode_i,
  input  logic [31:0]                      exe_rs1_i,
  input  logic [lanes_p-1:0][31:0]         exe_rs2_i,
  input  logic [4:0]                       exe_rd_i,
  input  logic [11:0]                      mem_offset_i,
  input  logic [31:0]                      pc_plus4_i,
  input  logic                             icache_miss_i,
  output logic                             dmem_v_o,
  output logic                             dmem_w_o,
  output logic [$clog2(dmem_size_p)-1:0]   dmem_addr_o,
  output logic [lanes_p-1:0][31:0]         dmem_data_o,
  output logic [lanes_p-1:0][3:0]          dmem_mask_o,
  output logic [1:0]                       byte_sel_o,
  lsu_vec_if.master                        remote,
  output logic                             misalign_o
);
  localparam int LG  = $clog2(lanes_p);
  localparam int DAW = $clog2(dmem_size_p);

  logic [31:0] w_addr, w_req_addr, w_fmt_data;
  logic [3:0]  w_fmt_mask;
  logic        w_fire, w_simd, w_local, w_misal, w_local_op, w_remote, w_accept;
  remote_req_s w_req, r_req;
  lsu_vec_state_e r_state;
  logic        r_live;  // low until the first clock after reset, keeps ready low in reset

  assign w_addr     = exe_rs1_i + {{20{mem_offset_i[11]}}, mem_offset_i};
  assign w_fire     = exe_v_i & exe_ready_o;
  // AMOs always go remote and are never split
  assign w_simd     = exe_decode_i.simd & ~exe_decode_i.amo;
  assign w_local    = (w_addr[31:12] == 20'd0) & ~exe_decode_i.amo;
  assign w_misal    = |w_addr[2+LG-1:0];
  assign w_local_op = ~icache_miss_i & w_local
                    & (exe_decode_i.load | exe_decode_i.store | exe_decode_i.lr);
  // remote LR has no meaning and is silently dropped
  assign w_remote   = icache_miss_i | (~w_local & ~exe_decode_i.lr
                    & (exe_decode_i.load | exe_decode_i.store | exe_decode_i.amo));

  lsu_vec_store_fmt u_fmt (
    .i_data (exe_rs2_i[0]),
    .i_byte (exe_decode_i.is_byte),
    .i_hex  (exe_decode_i.is_hex),
    .i_sel  (w_addr[1:0]),
    .o_data (w_fmt_data),
    .o_mask (w_fmt_mask)
  );

  assign dmem_v_o    = w_fire & w_local_op & ~(w_simd & w_misal);
  assign dmem_w_o    = dmem_v_o & exe_decode_i.store;
  assign misalign_o  = w_fire & w_local_op & w_simd & w_misal;
  assign dmem_addr_o = w_addr[2+LG +: DAW];
  assign byte_sel_o  = w_addr[1:0];

  // SIMD rows are aligned so raw lane words line up with the shared mask
  for (genvar i = 0; i < lanes_p; i++) begin : g_lane
    assign dmem_data_o[i] = w_simd ? exe_rs2_i[i] : w_fmt_data;
    assign dmem_mask_o[i] = (w_simd || (w_addr[2 +: LG] == LG'(i))) ? w_fmt_mask : 4'h0;
  end

  assign w_req_addr = icache_miss_i ? ((pc_plus4_i - 32'd4) | bsg_dram_npa_prefix_gp) : w_addr;

  always_comb begin
    w_req                        = '0;
    w_req.addr                   = w_req_addr;
    w_req.reg_id                 = exe_rd_i;
    w_req.mask                   = 4'hF;
    w_req.load_info.icache_fetch = icache_miss_i;
    w_req.load_info.part_sel     = w_req_addr[1:0];
    if (!icache_miss_i) begin
      w_req.write_not_read           = exe_decode_i.store;
      w_req.is_amo                   = exe_decode_i.amo;
      w_req.amo_type                 = exe_decode_i.amo_type;
      w_req.mask                     = w_fmt_mask;
      w_req.payload                  = w_fmt_data;
      w_req.load_info.float_wb       = exe_decode_i.write_frd;
      w_req.load_info.is_unsigned_op = exe_decode_i.is_unsigned;
      w_req.load_info.is_byte_op     = exe_decode_i.is_byte;
      w_req.load_info.is_hex_op      = exe_decode_i.is_hex;
    end
  end

  assign w_accept            = remote.remote_req_v & remote.remote_req_ready;
  assign remote.remote_req_v = (r_state != LSU_IDLE);
  assign exe_ready_o         = r_live & (r_state == LSU_IDLE);

`ifdef LSU_VEC_REMOTE_SIMD_EN
  logic [LG-1:0]              r_cnt;
  logic [lanes_p-1:0][31:0]   r_lane_data;

  always_comb begin
    remote.remote_req = r_req;
    if (r_state == LSU_BURST) remote.remote_req.payload = r_lane_data[r_cnt];
  end
`else
  assign remote.remote_req = r_req;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= LSU_IDLE;
      r_live      <= 1'b0;
      r_req       <= '0;
`ifdef LSU_VEC_REMOTE_SIMD_EN
      r_cnt       <= '0;
      r_lane_data <= '0;
`endif
    end else begin
      r_live <= 1'b1;
      case (r_state)
        LSU_IDLE: if (w_fire && w_remote) begin
          r_req <= w_req;
`ifdef LSU_VEC_REMOTE_SIMD_EN
          r_lane_data <= exe_rs2_i;
          r_cnt       <= '0;
          r_state     <= (w_simd && !icache_miss_i) ? LSU_BURST : LSU_SEND;
`else
          r_state     <= LSU_SEND;
`endif
        end
        LSU_SEND: if (w_accept) r_state <= LSU_IDLE;
`ifdef LSU_VEC_REMOTE_SIMD_EN
        LSU_BURST: if (w_accept) begin
          if (r_cnt == LG'(lanes_p - 1)) begin
            r_state <= LSU_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt        <= r_cnt + 1'b1;
            r_req.addr   <= r_req.addr + 32'd4;
            r_req.reg_id <= r_req.reg_id + 5'd1;
          end
        end
`endif
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
`ifndef LSU_VEC_REMOTE_SIMD_EN
  always @(posedge clk_i)
    if (reset_n_i && w_fire && w_remote && w_simd && !icache_miss_i)
      $error("[BSG_ERROR] remote SIMD not supported");
`endif
  a_amo_not_local: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(dmem_v_o && exe_decode_i.amo));
  a_lanes_pow2: assert property (@(posedge clk_i)
    ((lanes_p & (lanes_p - 1)) == 0) && (lanes_p >= 2) && (lanes_p <= lsu_vec_max_lanes_gp));
`endif

endmodule

// File: tb/tb_lsu_vec.sv
// tb_lsu_vec: directed self-checking bench for lsu_vec (lanes_p=4).
// Local ops run from a vector table; remote, icache-miss, AMO, burst and
// reset cases are hand-written sequences.
module tb_lsu_vec;
  import lsu_vec_pkg::*;

  localparam int L = 4;
`ifdef LSU_VEC_REMOTE_SIMD_EN
  localparam int NBEATS = 4;
`else
  localparam int NBEATS = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 exe_v, exe_ready, miss;
  decode_s              dec;
  logic [31:0]          rs1, pc4;
  logic [L-1:0][31:0]   rs2;
  logic [4:0]           rd;
  logic [11:0]          off;
  logic                 dmem_v, dmem_w, misal;
  logic [9:0]           dmem_addr;
  logic [L-1:0][31:0]   dmem_data;
  logic [L-1:0][3:0]    dmem_mask;
  logic [1:0]           bsel;

  lsu_vec_if rif();

  lsu_vec #(.data_width_p(32), .dmem_size_p(1024), .lanes_p(L)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .exe_v_i(exe_v), .exe_ready_o(exe_ready), .exe_decode_i(dec),
    .exe_rs1_i(rs1), .exe_rs2_i(rs2), .exe_rd_i(rd), .mem_offset_i(off),
    .pc_plus4_i(pc4), .icache_miss_i(miss),
    .dmem_v_o(dmem_v), .dmem_w_o(dmem_w), .dmem_addr_o(dmem_addr),
    .dmem_data_o(dmem_data), .dmem_mask_o(dmem_mask), .byte_sel_o(bsel),
    .remote(rif), .misalign_o(misal)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic decode_s mk(input bit ld, st, simd, b, h, amo, lr);
    decode_s d = '0;
    d.load = ld; d.store = st; d.simd = simd; d.is_byte = b; d.is_hex = h; d.amo = amo; d.lr = lr;
    return d;
  endfunction

  task automatic idle_in();
    exe_v = 0; dec = '0; rs1 = 0; off = 0; rs2 = '0; rd = 0; pc4 = 0; miss = 0;
  endtask

  typedef struct {
    string              nm;
    logic               v;
    decode_s            dec;
    logic [31:0]        rs1;
    logic [11:0]        off;
    logic [L-1:0][31:0] rs2;
    logic               e_v, e_w;
    logic [9:0]         e_row;
    logic [L-1:0][31:0] e_data;
    logic [L-1:0][3:0]  e_mask;
    logic [1:0]         e_bsel;
    logic               e_mis;
  } vec_t;

  vec_t tbl[10];
  decode_s D_SW, D_SB, D_SH, D_LW, D_VSW, D_LR, D_G;
  logic [L-1:0][31:0] vdat;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    D_SW  = mk(0,1,0,0,0,0,0);
    D_SB  = mk(0,1,0,1,0,0,0);
    D_SH  = mk(0,1,0,0,1,0,0);
    D_LW  = mk(1,0,0,0,0,0,0);
    D_VSW = mk(0,1,1,0,0,0,0);
    D_LR  = mk(0,0,0,0,0,0,1);
`ifdef LSU_VEC_REMOTE_SIMD_EN
    D_G   = D_VSW;
`else
    D_G   = D_SW;
`endif
    vdat = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};

    //            name        v  dec    rs1      off     rs2                                       v w row     data                                  mask      bs mis
    tbl[0] = '{"sw_lane1",    1, D_SW,  32'h100, 12'h004, {96'h0, 32'hDEADBEEF},                   1,1,10'h010,{4{32'hDEADBEEF}},                     16'h00F0, 2'd0, 0};
    tbl[1] = '{"sb_0x203",    1, D_SB,  32'h203, 12'h000, {96'h0, 32'h000000AB},                   1,1,10'h020,{4{32'hABABABAB}},                     16'h0008, 2'd3, 0};
    tbl[2] = '{"sh_negoff",   1, D_SH,  32'h300, 12'hFFE, {96'h0, 32'hCAFE1234},                   1,1,10'h02F,{4{32'h12341234}},                     16'hC000, 2'd2, 0};
    tbl[3] = '{"lw_lane2",    1, D_LW,  32'h040, 12'h008, 128'h0,                                  1,0,10'h004,128'h0,                                16'h0F00, 2'd0, 0};
    tbl[4] = '{"simd_sw",     1, D_VSW, 32'h200, 12'h010, {32'h44444444,32'h33333333,32'h22222222,32'h11111111},
                                                                                                   1,1,10'h021,{32'h44444444,32'h33333333,32'h22222222,32'h11111111},16'hFFFF,2'd0,0};
    tbl[5] = '{"simd_misal",  1, D_VSW, 32'h200, 12'h004, {4{32'h55555555}},                       0,0,10'h0,  128'h0,                                16'h0,    2'd0, 1};
    tbl[6] = '{"sw_top_loc",  1, D_SW,  32'hFFC, 12'h000, {96'h0, 32'h5A5A5A5A},                   1,1,10'h0FF,{4{32'h5A5A5A5A}},                     16'hF000, 2'd0, 0};
    tbl[7] = '{"idle_nov",    0, D_SW,  32'h100, 12'h000, 128'h0,                                  0,0,10'h0,  128'h0,                                16'h0,    2'd0, 0};
    tbl[8] = '{"lr_local",    1, D_LR,  32'h010, 12'h000, 128'h0,                                  1,0,10'h001,128'h0,                                16'h000F, 2'd0, 0};
    tbl[9] = '{"sb_negwrap",  1, D_SB,  32'h010, 12'hFFF, {96'h0, 32'h00000077},                   1,1,10'h000,{4{32'h77777777}},                     16'h8000, 2'd3, 0};

    // reset state
    idle_in();
    rif.remote_req_ready = 0;
    rst_n = 0;
    exe_v = 1; dec = D_SW; rs1 = 32'h100;
    #12;
    chk("rst_exe_ready", exe_ready, 0);
    chk("rst_req_v", rif.remote_req_v, 0);
    chk("rst_misalign", misal, 0);
    chk("rst_dmem_v", dmem_v, 0);
    chk("rst_req_regs", rif.remote_req, 0);
    idle_in();
    @(negedge clk); rst_n = 1;
    @(negedge clk); #2;
    chk("post_rst_ready", exe_ready, 1);

    // local table
    foreach (tbl[i]) begin
      @(negedge clk);
      exe_v = tbl[i].v; dec = tbl[i].dec; rs1 = tbl[i].rs1; off = tbl[i].off; rs2 = tbl[i].rs2;
      #2;
      chk({tbl[i].nm, ".v"},    dmem_v, tbl[i].e_v);
      chk({tbl[i].nm, ".w"},    dmem_w, tbl[i].e_w);
      chk({tbl[i].nm, ".mis"},  misal,  tbl[i].e_mis);
      chk({tbl[i].nm, ".bsel"}, bsel,   tbl[i].e_bsel);
      if (tbl[i].e_v) begin
        chk({tbl[i].nm, ".row"},  dmem_addr, tbl[i].e_row);
        chk({tbl[i].nm, ".data"}, dmem_data, tbl[i].e_data);
        chk({tbl[i].nm, ".mask"}, dmem_mask, tbl[i].e_mask);
      end
    end
    @(negedge clk); idle_in();
    #2 chk("local_no_remote", rif.remote_req_v, 0);

    // remote scalar store, TX stalls one extra cycle
    @(negedge clk);
    dec = D_SW; rs1 = 32'h8000_0010; rs2[0] = 32'h11223344; rd = 3; exe_v = 1; rif.remote_req_ready = 0;
    #2 chk("rs_dmem_v", dmem_v, 0);
    @(negedge clk); idle_in(); #2;
    chk("rs_v", rif.remote_req_v, 1);
    chk("rs_ready_low", exe_ready, 0);
    chk("rs_addr", rif.remote_req.addr, 32'h8000_0010);
    chk("rs_payload", rif.remote_req.payload, 32'h11223344);
    chk("rs_wnr", rif.remote_req.write_not_read, 1);
    chk("rs_regid", rif.remote_req.reg_id, 3);
    @(negedge clk); #2;
    chk("rs_hold_v", rif.remote_req_v, 1);
    chk("rs_hold_addr", rif.remote_req.addr, 32'h8000_0010);
    rif.remote_req_ready = 1;
    @(negedge clk); #2;
    chk("rs_done_v", rif.remote_req_v, 0);
    chk("rs_done_ready", exe_ready, 1);

    // icache miss
    @(negedge clk);
    miss = 1; pc4 = 32'h1004; exe_v = 1; dec = D_SW; rs1 = 32'h8000_0000;
    @(negedge clk); idle_in(); #2;
    chk("ic_v", rif.remote_req_v, 1);
    chk("ic_addr", rif.remote_req.addr, 32'h1000 | bsg_dram_npa_prefix_gp);
    chk("ic_fetch", rif.remote_req.load_info.icache_fetch, 1);
    chk("ic_wnr", rif.remote_req.write_not_read, 0);
    @(negedge clk); #2;
    chk("ic_done_v", rif.remote_req_v, 0);

    // remote LR is dropped
    @(negedge clk);
    dec = D_LR; rs1 = 32'h8000_0000; exe_v = 1;
    @(negedge clk); idle_in(); #2;
    chk("rlr_v", rif.remote_req_v, 0);
    chk("rlr_ready", exe_ready, 1);

    // AMO to a local address with simd set: remote, single beat
    @(negedge clk);
    dec = mk(0,0,1,0,0,1,0); dec.amo_type = 4'h2; rs1 = 32'h20; rs2 = vdat; rs2[0] = 32'hC0FFEE00; rd = 7; exe_v = 1;
    #2;
    chk("amo_dmem_v", dmem_v, 0);
    chk("amo_misal", misal, 0);
    @(negedge clk); idle_in(); #2;
    chk("amo_v", rif.remote_req_v, 1);
    chk("amo_is_amo", rif.remote_req.is_amo, 1);
    chk("amo_type", rif.remote_req.amo_type, 4'h2);
    chk("amo_addr", rif.remote_req.addr, 32'h20);
    chk("amo_payload", rif.remote_req.payload, 32'hC0FFEE00);
    @(negedge clk); #2;
    chk("amo_single", rif.remote_req_v, 0);
    chk("amo_ready", exe_ready, 1);

`ifdef LSU_VEC_REMOTE_SIMD_EN
    // remote SIMD burst, TX always ready
    @(negedge clk);
    dec = D_VSW; rs1 = 32'h8000_0000; rs2 = vdat; rd = 8; exe_v = 1;
    @(negedge clk); idle_in();
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge clk);
      #2;
      chk($sformatf("bu_v%0d", b), rif.remote_req_v, 1);
      chk($sformatf("bu_rdy%0d", b), exe_ready, 0);
      chk($sformatf("bu_addr%0d", b), rif.remote_req.addr, 32'h8000_0000 + 32'(4*b));
      chk($sformatf("bu_reg%0d", b), rif.remote_req.reg_id, 5'(8+b));
      chk($sformatf("bu_data%0d", b), rif.remote_req.payload, vdat[b]);
    end
    @(negedge clk); #2;
    chk("bu_end_v", rif.remote_req_v, 0);
    chk("bu_end_ready", exe_ready, 1);

    // same burst with TX stalled for 3 cycles on beat 2
    @(negedge clk);
    dec = D_VSW; rs1 = 32'h8000_0000; rs2 = vdat; rd = 8; exe_v = 1;
    @(negedge clk); idle_in();
    for (int c = 1; c <= 7; c++) begin
      automatic int eb = (c <= 2) ? c - 1 : (c <= 6) ? 2 : 3;
      if (c > 1) @(negedge clk);
      rif.remote_req_ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      #2;
      chk($sformatf("st_v_c%0d", c), rif.remote_req_v, 1);
      chk($sformatf("st_addr_c%0d", c), rif.remote_req.addr, 32'h8000_0000 + 32'(4*eb));
      chk($sformatf("st_reg_c%0d", c), rif.remote_req.reg_id, 5'(8+eb));
      chk($sformatf("st_data_c%0d", c), rif.remote_req.payload, vdat[eb]);
    end
    @(negedge clk); #2;
    chk("st_end_v", rif.remote_req_v, 0);
    chk("st_end_ready", exe_ready, 1);
`endif

    // reset pulse while a remote op is outstanding
    @(negedge clk);
    rif.remote_req_ready = (NBEATS > 1);
    dec = D_G; rs1 = 32'h8000_0100; rs2 = vdat; rd = 5; exe_v = 1;
    @(negedge clk); idle_in();
    @(negedge clk); rif.remote_req_ready = 0;
    @(negedge clk); #2;
    chk("mr_pre_v", rif.remote_req_v, 1);
    #1 rst_n = 0;
    #1;
    chk("mr_v", rif.remote_req_v, 0);
    chk("mr_ready", exe_ready, 0);
    chk("mr_regs", rif.remote_req, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk); #2;
    chk("mr_idle_ready", exe_ready, 1);
    rif.remote_req_ready = 1;
    @(negedge clk);
    dec = D_G; rs1 = 32'h9000_0000; rs2 = vdat; rd = 2; exe_v = 1;
    @(negedge clk); idle_in(); #2;
    chk("mr_new_addr", rif.remote_req.addr, 32'h9000_0000);
    chk("mr_new_reg", rif.remote_req.reg_id, 2);
    chk("mr_new_data", rif.remote_req.payload, vdat[0]);
    repeat (NBEATS) @(negedge clk);
    #2;
    chk("mr_end_v", rif.remote_req_v, 0);
    chk("mr_end_ready", exe_ready, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
